// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared constants, state encoding and target clamp for the pwm soft-start sequencer.
package pwm_ramp_ctrl_pkg;

  localparam int DC_W_DEF     = 7;
  localparam int DC_MAX_DEF   = 100;
  localparam int PERIOD_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RAMP = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_STOP = 2'd3;

  function automatic int unsigned clamp_tgt(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Target-duty valid/ready handshake between the control registers and the ramp sequencer.
interface pwm_ramp_ctrl_if
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int DC_W = DC_W_DEF
);
  logic            tgt_valid;
  logic            tgt_ready;
  logic [DC_W-1:0] tgt_dc;

  modport master (output tgt_valid, output tgt_dc, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_dc, output tgt_ready);
endinterface

// File: rtl/pwm_ramp_ctrl_timer.sv
// PWM period counter with registered wrap tick, plus the step counter that paces ramp steps.
module pwm_ramp_ctrl_timer
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int PERIOD_W     = PERIOD_W_DEF,
  parameter int STEP_PERIODS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic step_clr,
  output logic period_tick,
  output logic step_en
);

  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_PERIODS - 1);

  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic                period_tick_q, period_tick_d;
  logic [SC_W-1:0]     step_cnt_q, step_cnt_d;

  always_comb begin
    per_cnt_d     = per_cnt_q + PERIOD_W'(1);
    // tick lands in the same clk the counter reads 0, keeping phase with the pwm counter
    period_tick_d = &per_cnt_q;
    step_cnt_d    = step_cnt_q;
    if (step_clr) begin
      step_cnt_d = '0;
    end else if (period_tick_q) begin
      step_cnt_d = (step_cnt_q == SC_LAST) ? '0 : step_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_q     <= '0;
      period_tick_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      per_cnt_q     <= per_cnt_d;
      period_tick_q <= period_tick_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign period_tick = period_tick_q;
  assign step_en     = period_tick_q & ~step_clr & (step_cnt_q == SC_LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: slews pwm duty toward an accepted target at period boundaries.
//   state | meaning
//   IDLE  | dc held at 0, waiting for en with a non-zero target
//   RAMP  | dc stepping toward the effective target on step_en
//   HOLD  | dc equals the non-zero effective target
//   STOP  | emergency stop latched, dc and target forced to 0
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int DC_W         = DC_W_DEF,
  parameter int DC_MAX       = DC_MAX_DEF,
  parameter int PERIOD_W     = PERIOD_W_DEF,
  parameter int STEP_PERIODS = 4,
  parameter int STEP_SIZE    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            estop,
  pwm_ramp_ctrl_if.slave  tgt_if,
  output logic [DC_W-1:0] dc,
  output logic            period_tick,
  output logic            busy,
  output logic            at_target,
  output logic            stopped
);

  localparam logic [DC_W:0] STEP_X = (DC_W + 1)'(STEP_SIZE);

  logic            step_en, step_clr;
  state_t          state_q, state_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic [DC_W-1:0] tgt_q, tgt_d;
  logic            tgt_ready_q, tgt_ready_d;
  logic            busy_q, busy_d;
  logic            at_target_q, at_target_d;
  logic            stopped_q, stopped_d;

  logic            accept;
  logic [DC_W-1:0] eff, tgt_clamped;
  logic [DC_W:0]   dc_x, eff_x, gap_x, stride_x;

  pwm_ramp_ctrl_timer #(
    .PERIOD_W     (PERIOD_W),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .step_clr    (step_clr),
    .period_tick (period_tick),
    .step_en     (step_en)
  );

  assign step_clr    = (state_q != ST_RAMP);
  assign tgt_clamped = DC_W'(clamp_tgt(32'(tgt_if.tgt_dc), DC_MAX));

  always_comb begin
    accept   = tgt_if.tgt_valid & tgt_ready_q;
    eff      = en ? tgt_q : '0;
    dc_x     = {1'b0, dc_q};
    eff_x    = {1'b0, eff};
    gap_x    = (eff_x > dc_x) ? (eff_x - dc_x) : (dc_x - eff_x);
    stride_x = (gap_x < STEP_X) ? gap_x : STEP_X;

    state_d = state_q;
    dc_d    = dc_q;
    // a target accepted on a step_en clk only affects the following step
    tgt_d   = accept ? tgt_clamped : tgt_q;

    case (state_q)
      ST_IDLE: begin
        dc_d = '0;
        if (en && (eff != '0)) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (dc_q == eff) begin
          state_d = (eff == '0) ? ST_IDLE : ST_HOLD;
        end else if (step_en) begin
          dc_d = (eff_x > dc_x) ? DC_W'(dc_x + stride_x) : DC_W'(dc_x - stride_x);
        end
      end
      ST_HOLD: begin
        if (eff != dc_q) state_d = ST_RAMP;
      end
      ST_STOP: begin
        dc_d  = '0;
        tgt_d = '0;
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (estop) begin
      state_d = ST_STOP;
      dc_d    = '0;
      tgt_d   = '0;
    end

    tgt_ready_d = (state_d != ST_STOP);
    busy_d      = (state_d == ST_RAMP);
    at_target_d = (state_d == ST_HOLD);
    stopped_d   = (state_d == ST_STOP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dc_q        <= '0;
      tgt_q       <= '0;
      tgt_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b0;
      stopped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_q        <= dc_d;
      tgt_q       <= tgt_d;
      tgt_ready_q <= tgt_ready_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
      stopped_q   <= stopped_d;
    end
  end

  assign tgt_if.tgt_ready = tgt_ready_q;
  assign dc               = dc_q;
  assign busy             = busy_q;
  assign at_target        = at_target_q;
  assign stopped          = stopped_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a default-period instance and a short-period instance share stimulus.
module tb_pwm_ramp_ctrl;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       en        = 1'b0;
  logic       estop     = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [6:0] tgt_dc    = '0;
  logic       sel       = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] dc_s, dc_f, dc_o;
  logic       tick_s, tick_f, tick_o;
  logic       busy_s, busy_f, busy_o;
  logic       at_s, at_f, at_o;
  logic       stop_s, stop_f, stop_o;
  logic       rdy_o;

  pwm_ramp_ctrl_if if_s ();
  pwm_ramp_ctrl_if if_f ();

  assign if_s.tgt_valid = tgt_valid;
  assign if_s.tgt_dc    = tgt_dc;
  assign if_f.tgt_valid = tgt_valid;
  assign if_f.tgt_dc    = tgt_dc;

  pwm_ramp_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .estop       (estop),
    .tgt_if      (if_s),
    .dc          (dc_s),
    .period_tick (tick_s),
    .busy        (busy_s),
    .at_target   (at_s),
    .stopped     (stop_s)
  );

  pwm_ramp_ctrl #(.PERIOD_W(4)) u_fast (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .estop       (estop),
    .tgt_if      (if_f),
    .dc          (dc_f),
    .period_tick (tick_f),
    .busy        (busy_f),
    .at_target   (at_f),
    .stopped     (stop_f)
  );

  always #5 clk = ~clk;

  always_comb begin
    dc_o   = sel ? dc_f   : dc_s;
    tick_o = sel ? tick_f : tick_s;
    busy_o = sel ? busy_f : busy_s;
    at_o   = sel ? at_f   : at_s;
    stop_o = sel ? stop_f : stop_s;
    rdy_o  = sel ? if_f.tgt_ready : if_s.tgt_ready;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept_tgt(input int v);
    tgt_dc    = 7'(v);
    tgt_valid = 1'b1;
    step(1);
    tgt_valid = 1'b0;
  endtask

  // watch dc until it reaches target; each change must be one unit in dir, right after a tick
  task automatic ramp_to(input string tag, input int target, input int dir,
                         input int interval, input int budget, output int gaps);
    int prev_dc, prev_tick, cur, start, mx, last, n;
    bit done;
    prev_dc   = dc_o;
    prev_tick = tick_o;
    start     = prev_dc;
    mx        = prev_dc;
    last      = -1;
    n         = 0;
    gaps      = 0;
    done      = (prev_dc == target);
    while (!done && n < budget) begin
      step(1);
      n++;
      cur = dc_o;
      if (cur != prev_dc) begin
        check_eq({tag, "_delta"}, cur - prev_dc, dir);
        check_eq({tag, "_on_tick"}, prev_tick, 1);
        if (last >= 0) check_eq({tag, "_interval"}, n - last, interval);
        last = n;
      end
      if (cur > mx) mx = cur;
      if (cur != target && !busy_o) gaps++;
      prev_dc   = cur;
      prev_tick = tick_o;
      if (cur == target) done = 1'b1;
    end
    check_eq({tag, "_reached"}, dc_o, target);
    check_eq({tag, "_max"}, mx, (start > target) ? start : target);
  endtask

  initial begin
    int g, n;
    bit found;

    // reset values
    #2 reset = 1'b0;
    #1;
    check_eq("rst_dc", dc_o, 0);
    check_eq("rst_tick", tick_o, 0);
    check_eq("rst_ready", rdy_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_at", at_o, 0);
    check_eq("rst_stop", stop_o, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step(1);
    check_eq("idle_ready", rdy_o, 1);

    // 1: soft start to 10, one step per 1024 clk
    en = 1'b1;
    accept_tgt(10);
    ramp_to("t1", 10, 1, 1024, 12000, g);
    step(2);
    check_eq("t1_at", at_o, 1);
    check_eq("t1_busy", busy_o, 0);
    check_eq("t1_dc", dc_o, 10);

    // 2: target 120 clamps to 100 (short-period instance from here)
    sel = 1'b1;
    check_eq("t2_start_at", at_o, 1);
    check_eq("t2_start_dc", dc_o, 10);
    accept_tgt(120);
    ramp_to("t2", 100, 1, 64, 6200, g);
    step(2);
    check_eq("t2_at", at_o, 1);
    step(200);
    check_eq("t2_hold_dc", dc_o, 100);

    // 3: ramp up through 40 then retarget to 20 mid-ramp
    accept_tgt(30);
    ramp_to("t3_down", 30, -1, 64, 4800, g);
    accept_tgt(45);
    ramp_to("t3_up", 40, 1, 64, 1000, g);
    check_eq("t3_busy_mid", busy_o, 1);
    accept_tgt(20);
    ramp_to("t3_rev", 20, -1, 64, 1600, g);
    step(2);
    check_eq("t3_at", at_o, 1);
    check_eq("t3_dc", dc_o, 20);

    // 4: hold at 50, drop en, ramp to 0 with busy throughout
    accept_tgt(50);
    ramp_to("t4_up", 50, 1, 64, 2200, g);
    step(2);
    check_eq("t4_at", at_o, 1);
    en = 1'b0;
    step(2);
    check_eq("t4_busy_start", busy_o, 1);
    ramp_to("t4_down", 0, -1, 64, 3400, g);
    check_eq("t4_busy_gaps", g, 0);
    step(2);
    check_eq("t4_idle_busy", busy_o, 0);
    check_eq("t4_idle_at", at_o, 0);
    check_eq("t4_idle_stop", stop_o, 0);

    // 5: estop together with a target offer at dc=60
    en = 1'b1;
    accept_tgt(60);
    ramp_to("t5_up", 60, 1, 64, 4000, g);
    step(2);
    check_eq("t5_at", at_o, 1);
    estop     = 1'b1;
    tgt_dc    = 7'd30;
    tgt_valid = 1'b1;
    step(1);
    check_eq("t5_dc", dc_o, 0);
    check_eq("t5_stopped", stop_o, 1);
    check_eq("t5_ready", rdy_o, 0);
    check_eq("t5_at_clr", at_o, 0);
    estop     = 1'b0;
    tgt_valid = 1'b0;
    step(5);
    check_eq("t5_latched", stop_o, 1);
    en = 1'b0;
    step(1);
    check_eq("t5_exit_stop", stop_o, 0);
    check_eq("t5_exit_ready", rdy_o, 1);
    en = 1'b1;
    step(300);
    check_eq("t5_dropped_dc", dc_o, 0);
    check_eq("t5_dropped_busy", busy_o, 0);

    // 6: reset mid-ramp on the default instance
    sel = 1'b0;
    accept_tgt(50);
    n = 0;
    while (dc_o != 7'd2 && n < 4000) begin
      step(1);
      n++;
    end
    check_eq("t6_pre_dc", dc_o, 2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_dc", dc_o, 0);
    check_eq("t6_rst_tick", tick_o, 0);
    check_eq("t6_rst_busy", busy_o, 0);
    check_eq("t6_rst_at", at_o, 0);
    check_eq("t6_rst_stop", stop_o, 0);
    check_eq("t6_rst_ready", rdy_o, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n     = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      step(1);
      n++;
      if (tick_o) found = 1'b1;
    end
    check_eq("t6_first_tick", n, 256);
    step(1);
    check_eq("t6_tick_width", tick_o, 0);
    check_eq("t6_dc", dc_o, 0);
    check_eq("t6_ready", rdy_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
